// File: rtl/mem_rd_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_arbiter2
// Purpose  : Round-robin read arbiter sharing one single-port wide memory
//            between two requesters. The owner of each accepted read is kept
//            in an in-order ID FIFO so that each memory response can be routed
//            back to the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rd_arbiter2 #(
  parameter int AW      = 18,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  // requester 0 (sequential core)
  input  logic                       r0_req_valid,
  output logic                       r0_req_ready,
  input  logic [AW-1:0]              r0_req_addr,
  output logic                       r0_resp_valid,
  output logic [31:0]                r0_resp_rdata,
  // requester 1 (SIMD4 core)
  input  logic                       r1_req_valid,
  output logic                       r1_req_ready,
  input  logic [AW-1:0]              r1_req_addr,
  output logic                       r1_resp_valid,
  output logic [31:0]                r1_resp_rdata,
  // memory side
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [AW-1:0]              mem_req_addr,
  output logic                       mem_req_we,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_rdata,
  // status
  output logic [CNT_W-1:0]           o_grant_cnt0,
  output logic [CNT_W-1:0]           o_grant_cnt1,
  output logic [$clog2(MAX_OUT):0]   o_outstanding,
  output logic                       o_err_orphan
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL_LVL = OW'(MAX_OUT);

  // State
  logic                 rr_q,       rr_d;
  logic                 lock_vld_q, lock_vld_d;
  logic                 lock_id_q,  lock_id_d;
  logic [MAX_OUT-1:0]   fifo_q,     fifo_d;
  logic [PW-1:0]        wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q,   rd_ptr_d;
  logic [OW-1:0]        occ_q,      occ_d;
  logic [CNT_W-1:0]     cnt0_q,     cnt0_d;
  logic [CNT_W-1:0]     cnt1_q,     cnt1_d;
  logic                 orphan_q,   orphan_d;

  // Combinational decode
  logic                 owner;
  logic                 owner_valid;
  logic                 full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 pop;
  logic                 head_id;

  // Owner selection: a stalled grant stays locked, otherwise round-robin on contention
  always_comb begin
    if (lock_vld_q) begin
      owner = lock_id_q;
    end else if (r0_req_valid && r1_req_valid) begin
      owner = rr_q;
    end else begin
      owner = r1_req_valid;
    end
  end

  assign owner_valid = owner ? r1_req_valid : r0_req_valid;
  assign full        = (occ_q == FULL_LVL);
  assign fifo_empty  = (occ_q == '0);
  assign accept      = mem_req_valid && mem_req_ready;
  assign pop         = mem_resp_valid && !fifo_empty;
  assign head_id     = fifo_q[rd_ptr_q];

  assign mem_req_valid = owner_valid && !full;
  assign mem_req_addr  = owner ? r1_req_addr : r0_req_addr;
  assign mem_req_we    = 1'b0;

  assign r0_req_ready  = accept && !owner;
  assign r1_req_ready  = accept &&  owner;

  // Responses come back in request order, so the FIFO head names the owner
  assign r0_resp_valid = pop && !head_id;
  assign r1_resp_valid = pop &&  head_id;
  assign r0_resp_rdata = mem_resp_rdata;
  assign r1_resp_rdata = mem_resp_rdata;

  assign o_grant_cnt0  = cnt0_q;
  assign o_grant_cnt1  = cnt1_q;
  assign o_outstanding = occ_q;
  assign o_err_orphan  = orphan_q;

  // Next-state computation for lock, round-robin, FIFO, counters and error flag
  always_comb begin
    rr_d       = rr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    orphan_d   = orphan_q;

    if (accept) begin
      lock_vld_d       = 1'b0;
      rr_d             = !owner;
      fifo_d[wr_ptr_q] = owner;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      if (!owner && (cnt0_q != '1)) begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
      if (owner && (cnt1_q != '1)) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end
    end else if (mem_req_valid) begin
      // memory stalled: freeze grant and address until it accepts
      lock_vld_d = 1'b1;
      lock_id_d  = owner;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // push is blocked by full, so a simultaneous pop never underflows/overflows
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (mem_resp_valid && fifo_empty) begin
      orphan_d = 1'b1;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      orphan_q   <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      orphan_q   <= orphan_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rd_arbiter2
// Purpose  : Self-checking bench for mem_rd_arbiter2: randomized traffic
//            against a queue-based reference, a directed vector table and an
//            orphan-response / asynchronous-reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rd_arbiter2;

  localparam int AW      = 18;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 4;
  localparam int OW      = $clog2(MAX_OUT) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_req_valid, r0_req_ready, r0_resp_valid;
  logic [AW-1:0]     r0_req_addr;
  logic [31:0]       r0_resp_rdata;
  logic              r1_req_valid, r1_req_ready, r1_resp_valid;
  logic [AW-1:0]     r1_req_addr;
  logic [31:0]       r1_resp_rdata;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;
  logic [CNT_W-1:0]  o_grant_cnt0, o_grant_cnt1;
  logic [OW-1:0]     o_outstanding;
  logic              o_err_orphan;

  mem_rd_arbiter2 #(.AW(AW), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .r0_req_valid   (r0_req_valid),
    .r0_req_ready   (r0_req_ready),
    .r0_req_addr    (r0_req_addr),
    .r0_resp_valid  (r0_resp_valid),
    .r0_resp_rdata  (r0_resp_rdata),
    .r1_req_valid   (r1_req_valid),
    .r1_req_ready   (r1_req_ready),
    .r1_req_addr    (r1_req_addr),
    .r1_resp_valid  (r1_resp_valid),
    .r1_resp_rdata  (r1_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .o_grant_cnt0   (o_grant_cnt0),
    .o_grant_cnt1   (o_grant_cnt1),
    .o_outstanding  (o_outstanding),
    .o_err_orphan   (o_err_orphan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] resp_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {14'h0, a} ^ {a[7:0], 24'h0};
  endfunction

  task automatic drive_idle();
    r0_req_valid   = 1'b0;
    r0_req_addr    = '0;
    r1_req_valid   = 1'b0;
    r1_req_addr    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vector record: inputs for one cycle and the outputs expected in it
  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic          v1;
    logic [AW-1:0] a1;
    logic          mrdy;
    logic          rsv;
    logic [31:0]   rsd;
    logic          emv;
    logic [AW-1:0] ema;
    logic          erd0;
    logic          erd1;
    logic          ers0;
    logic          ers1;
    int            ec0;
    int            ec1;
    int            eout;
  } vec_t;

  vec_t tbl[18];

  // Reference model state (abstract view of the arbiter)
  int            held;     // requester whose stalled grant is frozen, -1 if none
  int            pref;     // requester preferred on the next contention
  int            cnt[2];
  bit            qid[$];
  logic [AW-1:0] qadr[$];
  logic          rv[2];
  logic [AW-1:0] ra[2];

  initial begin
    int  owner;
    bit  full, ev, acc, pop;

    rst = 1'b0;
    drive_idle();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    chk("reset_mem_req_valid", mem_req_valid, 1'b0);
    chk("reset_r0_req_ready", r0_req_ready, 1'b0);
    chk("reset_r1_req_ready", r1_req_ready, 1'b0);
    chk("reset_outstanding", o_outstanding, 0);
    chk("reset_cnt0", o_grant_cnt0, 0);
    chk("reset_cnt1", o_grant_cnt1, 0);
    chk("reset_orphan", o_err_orphan, 1'b0);
    chk("reset_we", mem_req_we, 1'b0);

    // ---------------- randomized traffic vs. reference ----------------
    held = -1; pref = 0; cnt[0] = 0; cnt[1] = 0;
    rv[0] = 1'b0; rv[1] = 1'b0; ra[0] = '0; ra[1] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      r0_req_valid   = rv[0];
      r0_req_addr    = ra[0];
      r1_req_valid   = rv[1];
      r1_req_addr    = ra[1];
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = (qid.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_resp_rdata = mem_resp_valid ? resp_word(qadr[0]) : $urandom();

      if (held >= 0)            owner = held;
      else if (rv[0] && rv[1])  owner = pref;
      else                      owner = rv[1] ? 1 : 0;
      full = (qid.size() == MAX_OUT);
      ev   = rv[owner] && !full;
      acc  = ev && mem_req_ready;
      pop  = mem_resp_valid && (qid.size() > 0);

      #1;
      chk("rnd_mem_req_valid", mem_req_valid, ev);
      if (ev) chk("rnd_mem_req_addr", mem_req_addr, ra[owner]);
      chk("rnd_r0_req_ready", r0_req_ready, acc && owner == 0);
      chk("rnd_r1_req_ready", r1_req_ready, acc && owner == 1);
      chk("rnd_r0_resp_valid", r0_resp_valid, pop && qid[0] == 1'b0);
      chk("rnd_r1_resp_valid", r1_resp_valid, pop && qid[0] == 1'b1);
      chk("rnd_r0_resp_rdata", r0_resp_rdata, mem_resp_rdata);
      chk("rnd_r1_resp_rdata", r1_resp_rdata, mem_resp_rdata);
      if (pop) chk("rnd_resp_data_order", r0_resp_rdata, resp_word(qadr[0]));
      chk("rnd_cnt0", o_grant_cnt0, cnt[0]);
      chk("rnd_cnt1", o_grant_cnt1, cnt[1]);
      chk("rnd_outstanding", o_outstanding, qid.size());
      chk("rnd_orphan", o_err_orphan, 1'b0);
      chk("rnd_we", mem_req_we, 1'b0);

      if (pop) begin
        void'(qid.pop_front());
        void'(qadr.pop_front());
      end
      if (acc) begin
        qid.push_back(owner[0]);
        qadr.push_back(ra[owner]);
        held = -1;
        pref = 1 - owner;
        if (cnt[owner] < CNT_MAX) cnt[owner]++;
      end else if (ev) begin
        held = owner;
      end
      for (int n = 0; n < 2; n++) begin
        if (acc && owner == n) begin
          if ($urandom_range(0, 1) == 1) ra[n] = AW'($urandom());
          else rv[n] = 1'b0;
        end else if (!rv[n] && $urandom_range(0, 1) == 1) begin
          rv[n] = 1'b1;
          ra[n] = AW'($urandom());
        end
      end
    end

    // ---------------- directed vector table ----------------
    //           v0 a0      v1 a1      rdy rsv rsd            emv ema     rd0 rd1 rs0 rs1 c0 c1 out
    tbl[0]  = '{0, 'h00,  0, 'h00,  0, 0, 32'h0,          0, 'h00,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 'h10,  0, 'h00,  1, 0, 32'h0,          1, 'h10,  1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 'h00,  0, 'h00,  0, 0, 32'h0,          0, 'h00,  0, 0, 0, 0, 1, 0, 1};
    tbl[3]  = '{0, 'h00,  0, 'h00,  0, 1, 32'hA1B2C3D4,   0, 'h00,  0, 0, 1, 0, 1, 0, 1};
    tbl[4]  = '{1, 'h20,  1, 'h30,  1, 0, 32'h0,          1, 'h30,  0, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 'h20,  1, 'h31,  1, 0, 32'h0,          1, 'h20,  1, 0, 0, 0, 1, 1, 1};
    tbl[6]  = '{1, 'h21,  1, 'h32,  0, 0, 32'h0,          1, 'h32,  0, 0, 0, 0, 2, 1, 2};
    tbl[7]  = '{1, 'h21,  1, 'h32,  0, 0, 32'h0,          1, 'h32,  0, 0, 0, 0, 2, 1, 2};
    tbl[8]  = '{1, 'h21,  1, 'h32,  0, 0, 32'h0,          1, 'h32,  0, 0, 0, 0, 2, 1, 2};
    tbl[9]  = '{1, 'h21,  1, 'h32,  1, 0, 32'h0,          1, 'h32,  0, 1, 0, 0, 2, 1, 2};
    tbl[10] = '{1, 'h21,  1, 'h33,  1, 0, 32'h0,          1, 'h21,  1, 0, 0, 0, 2, 2, 3};
    tbl[11] = '{1, 'h22,  1, 'h33,  1, 0, 32'h0,          0, 'h00,  0, 0, 0, 0, 3, 2, 4};
    tbl[12] = '{1, 'h22,  1, 'h33,  1, 1, 32'hD0D0_0000,  0, 'h00,  0, 0, 0, 1, 3, 2, 4};
    tbl[13] = '{1, 'h22,  1, 'h33,  1, 0, 32'h0,          1, 'h33,  0, 1, 0, 0, 3, 2, 3};
    tbl[14] = '{1, 'h22,  0, 'h00,  1, 1, 32'hD1D1_1111,  0, 'h00,  0, 0, 1, 0, 3, 3, 4};
    tbl[15] = '{1, 'h22,  0, 'h00,  0, 1, 32'hD2D2_2222,  1, 'h22,  0, 0, 0, 1, 3, 3, 3};
    tbl[16] = '{1, 'h22,  1, 'h34,  1, 1, 32'hD3D3_3333,  1, 'h22,  1, 0, 1, 0, 3, 3, 2};
    tbl[17] = '{0, 'h00,  0, 'h00,  0, 1, 32'hD4D4_4444,  0, 'h00,  0, 0, 0, 1, 4, 3, 2};

    reset_pulse();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      r0_req_valid   = tbl[i].v0;
      r0_req_addr    = tbl[i].a0;
      r1_req_valid   = tbl[i].v1;
      r1_req_addr    = tbl[i].a1;
      mem_req_ready  = tbl[i].mrdy;
      mem_resp_valid = tbl[i].rsv;
      mem_resp_rdata = tbl[i].rsd;
      #1;
      chk($sformatf("vec%0d_mem_req_valid", i), mem_req_valid, tbl[i].emv);
      if (tbl[i].emv) chk($sformatf("vec%0d_mem_req_addr", i), mem_req_addr, tbl[i].ema);
      chk($sformatf("vec%0d_r0_req_ready", i), r0_req_ready, tbl[i].erd0);
      chk($sformatf("vec%0d_r1_req_ready", i), r1_req_ready, tbl[i].erd1);
      chk($sformatf("vec%0d_r0_resp_valid", i), r0_resp_valid, tbl[i].ers0);
      chk($sformatf("vec%0d_r1_resp_valid", i), r1_resp_valid, tbl[i].ers1);
      if (tbl[i].rsv) begin
        chk($sformatf("vec%0d_r0_resp_rdata", i), r0_resp_rdata, tbl[i].rsd);
        chk($sformatf("vec%0d_r1_resp_rdata", i), r1_resp_rdata, tbl[i].rsd);
      end
      chk($sformatf("vec%0d_cnt0", i), o_grant_cnt0, tbl[i].ec0);
      chk($sformatf("vec%0d_cnt1", i), o_grant_cnt1, tbl[i].ec1);
      chk($sformatf("vec%0d_outstanding", i), o_outstanding, tbl[i].eout);
    end

    // ---------------- reset mid-burst, then orphan response ----------------
    // one read still outstanding here; a stalled request is pending
    @(negedge clk);
    drive_idle();
    r0_req_valid = 1'b1;
    r0_req_addr  = 'h40;
    #1;
    chk("pre_rst_outstanding", o_outstanding, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    chk("async_rst_outstanding", o_outstanding, 0);
    chk("async_rst_cnt0", o_grant_cnt0, 0);
    chk("async_rst_cnt1", o_grant_cnt1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("orphan_r0_resp_valid", r0_resp_valid, 1'b0);
    chk("orphan_r1_resp_valid", r1_resp_valid, 1'b0);
    chk("orphan_before_edge", o_err_orphan, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("orphan_set", o_err_orphan, 1'b1);
    chk("orphan_outstanding", o_outstanding, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("orphan_sticky", o_err_orphan, 1'b1);
    chk("orphan_cnt0", o_grant_cnt0, 0);
    chk("orphan_cnt1", o_grant_cnt1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
